muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide engine with its own sequencing FSM.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_fsm.sv | 72 +++++++
 rtl/muldiv_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and op-code helpers for the iterative RV32M multiply/divide engine.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    // MULHSU keeps a signed but treats b as unsigned.
    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_fsm.sv
// Sequencer for muldiv_unit: state register, iteration counter, datapath strobes
// and Moore busy/done decodes.
module muldiv_fsm
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic early,
    output logic load,
    output logic prep,
    output logic step,
    output logic fix,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic          last;

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (state == PREP)
                count <= '0;
            else if (state == CALC)
                count <= count + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PREP;
                    load      = 1'b1;
                end
            end
            PREP: state_nxt = early ? DONE : CALC;
            CALC: if (last) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                if (start) begin
                    state_nxt = PREP;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign prep = (state == PREP);
    assign step = (state == CALC);
    assign fix  = (state == FIX);
    assign busy = prep | step | fix;
    assign done = (state == DONE);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: sign-magnitude shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up and a held result.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic load, prep, step, fix, early;

    logic signed [WIDTH-1:0] op_a, op_b;
    logic [2:0]              op;
    logic                    sign_a, sign_b, sa_c, sb_c;
    logic [WIDTH-1:0]        mag_a, mag_b, mag_a_c, mag_b_c, shreg;
    logic [2*WIDTH-1:0]      acc, prod;
    logic [WIDTH:0]          rem, mul_sum, div_shift, div_diff;
    logic                    div_ge, div0, ovf;
    logic [WIDTH-1:0]        quo, rmd, fix_val, early_val;

    muldiv_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .early (early),
        .load  (load),
        .prep  (prep),
        .step  (step),
        .fix   (fix),
        .busy  (busy),
        .done  (done)
    );

    // Operand signs and magnitudes, formed from the latched operands in PREP.
    assign sa_c    = is_signed_a(op) & op_a[WIDTH-1];
    assign sb_c    = is_signed_b(op) & op_b[WIDTH-1];
    assign mag_a_c = sa_c ? $unsigned(-op_a) : $unsigned(op_a);
    assign mag_b_c = sb_c ? $unsigned(-op_b) : $unsigned(op_b);

    assign div0  = (op_b == '0);
    assign ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                   ($unsigned(op_a) == MIN_NEG) && ($unsigned(op_b) == '1);
    assign early = is_div(op) & (div0 | ovf);

    // Corner cases: op[1] selects remainder among the divide ops.
    always_comb begin
        early_val = '0;
        if (div0)
            early_val = op[1] ? $unsigned(op_a) : '1;
        else if (ovf)
            early_val = op[1] ? '0 : $unsigned(op_a);
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, mag_a} : '0);
        div_shift = {rem[WIDTH-1:0], shreg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_diff  = div_shift - {1'b0, mag_b};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            op_a <= a;
            op_b <= b;
            op   <= funct3;
        end
        if (prep) begin
            sign_a <= sa_c;
            sign_b <= sb_c;
            mag_a  <= mag_a_c;
            mag_b  <= mag_b_c;
            acc    <= '0;
            rem    <= '0;
            shreg  <= is_div(op) ? mag_a_c : mag_b_c;
        end else if (step) begin
            if (is_div(op)) begin
                rem   <= div_ge ? div_diff : div_shift;
                acc   <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                acc   <= {mul_sum, acc[WIDTH-1:1]};
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
        end
    end

    // FIX: signs were cleared in PREP for unsigned ops, so no op check here.
    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quo  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rmd  = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        unique case (op)
            OP_MUL:                        fix_val = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               fix_val = quo;
            default:                       fix_val = rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            result <= '0;
        else if (fix)
            result <= fix_val;
        else if (prep && early)
            result <= early_val;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases plus randomized ops checked
// against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    int   checks = 0;
    int   errors = 0;
    int   n;
    logic busy_ok;
    logic hold_ok;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, uy, p;
        logic [63:0]        pu;
        logic               ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = sx * sy; return p[31:0]; end
            3'b001: begin p = sx * sy; return p[63:32]; end
            3'b010: begin p = sx * uy; return p[63:32]; end
            3'b011: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
            3'b100: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            3'b101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 2;
        return 35;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Start sampled at the edge following this call; afterwards we sit in cycle C+1.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        funct3 = f; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        n       = 1;
        busy_ok = 1'b1;
    endtask

    task automatic wait_done();
        while (!done && n < 200) begin
            busy_ok &= busy;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input string tag);
        issue(f, x, y);
        a = ~x; b = ~y;
        wait_done();
        check({tag, " latency"}, 32'(n), 32'(exp_latency(f, x, y)));
        check({tag, " result"}, result, exp);
        check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        check({tag, " busy_in_done"}, {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; funct3 = 3'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'd0);
        reset = 1'b0;

        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7");
        do_op(3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7");
        do_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        do_op(3'b111, 32'd5, 32'd0, 32'd5, "remu_by0");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");

        // Start while busy is ignored.
        issue(3'b101, 32'd100, 32'd7);
        while (n < 5) begin @(posedge clk); #1; n++; end
        funct3 = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1; n++;
        start = 1'b0;
        wait_done();
        check("ignore latency", 32'(n), 32'd35);
        check("ignore result", result, 32'd14);

        // Reset mid-operation.
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        while (n < 12) begin @(posedge clk); #1; n++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset busy", {31'b0, busy}, 32'd0);
        check("midreset done", {31'b0, done}, 32'd0);
        check("midreset result", result, 32'd0);
        n = 0;
        repeat (40) begin @(posedge clk); #1; n += done ? 1 : 0; end
        check("midreset no_done", 32'(n), 32'd0);
        do_op(3'b000, 32'd6, 32'd7, 32'd42, "after_reset");

        // Back-to-back accept in the DONE cycle.
        issue(3'b000, 32'd3, 32'd4);
        wait_done();
        check("b2b first latency", 32'(n), 32'd35);
        check("b2b first result", result, 32'd12);
        funct3 = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        hold_ok = busy;
        while (!done && n < 200) begin
            hold_ok &= (result == 32'd12);
            @(posedge clk); #1;
            n++;
        end
        check("b2b second latency", 32'(n), 32'd35);
        check("b2b hold", {31'b0, hold_ok}, 32'd1);
        check("b2b second result", result, 32'hFFFF_FFFE);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = rnd_operand();
            rb = rnd_operand();
            do_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rnd%0d f%0d a%h b%h", i, rf, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
